sel_mode_top: RTL and testbench

SEL_MODE_TOP -- requirements
Module: sel_mode_top

---
 rtl/sel_mode_top.sv | 74 +++++++
 tb/tb_sel_mode_top.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sel_mode_top.sv
// rtl/sel_mode_top.sv - debounced 4-way mode select with one-hot LED and registered channel mux
module sel_mode_top #(
  parameter int STABLE_CYCLES = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [1:0] data,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  output logic [3:0] led,
  output logic [3:0] out
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);

  logic [1:0] sync1_q, sync2_q;
  logic [1:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] out_q, out_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      out_q   <= '0;
    end else begin
      sync1_q <= data;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
    end
  end

  // Any disagreement restarts the filter; the counter parks at CNT_MAX, where mode keeps reloading cand.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + 4'd1;
    end else if (cnt_q == CNT_MAX) begin
      mode_d = cand_q;
    end
  end

  // The mux follows the registered mode, so a new channel shows up one edge after the mode update.
  always_comb begin
    out_d = in0;
    case (mode_q)
      2'd0:    out_d = in0;
      2'd1:    out_d = in1;
      2'd2:    out_d = in2;
      default: out_d = in3;
    endcase
  end

  always_comb begin
    led = 4'b0001 << mode_q;
  end

  assign out = out_q;

endmodule

// File: tb/tb_sel_mode_top.sv
// tb/tb_sel_mode_top.sv - scoreboard bench for sel_mode_top
module tb_sel_mode_top;

  typedef struct {
    int         cyc;
    logic [3:0] led;
    logic [3:0] out;
    string      name;
  } exp_t;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [1:0] data;
  logic [3:0] in0, in1, in2, in3;
  logic [3:0] led, out;

  exp_t sb[$];
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;
  logic probe   = 1'b0;
  logic done    = 1'b0;

  sel_mode_top #(.STABLE_CYCLES(3)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .data     (data),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .led      (led),
    .out      (out)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

  task automatic expect_at(input int c, input logic [3:0] l, input logic [3:0] o, input string n);
    exp_t e;
    e.cyc = c; e.led = l; e.out = o; e.name = n;
    sb.push_back(e);
  endtask

  task automatic step_to(input int n);
    while (cyc_cnt < n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Stimulus: inputs change 1 ns after a rising edge; expectations are stamped with the cycle they apply to.
  initial begin
    logic [1:0] seq [6];
    logic [3:0] oh  [4];
    int k;
    seq = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1};
    oh  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    sys_rst_n = 1'b1;
    data = 2'd0;
    in0 = 4'b0001; in1 = 4'b0010; in2 = 4'b0100; in3 = 4'b1000;
    #1 sys_rst_n = 1'b0;

    step_to(2);
    expect_at(2, 4'b0001, 4'b0000, "rst_hold");
    sys_rst_n = 1'b1;
    expect_at(3, 4'b0001, 4'b0001, "release_out_in0");

    step_to(5);
    data = 2'd2;
    for (int c = 6; c <= 10; c++) expect_at(c, 4'b0001, 4'b0001, "pre_change_hold");
    expect_at(11, 4'b0100, 4'b0001, "mode2_led_e5");
    expect_at(12, 4'b0100, 4'b0100, "mode2_out_e6");

    step_to(15);
    data = 2'd0;
    expect_at(20, 4'b0100, 4'b0100, "back0_not_yet");
    expect_at(22, 4'b0001, 4'b0001, "back0_done");

    step_to(25);
    data = 2'd3;
    for (int c = 26; c <= 34; c++) expect_at(c, 4'b0001, 4'b0001, "short_pulse_ignored");
    step_to(27);
    data = 2'd0;

    for (int i = 0; i < 6; i++) begin
      k = 35 + 5 * i;
      step_to(k);
      data = seq[i];
      expect_at(k + 7, oh[seq[i]], oh[seq[i]], "seq_mode");
    end

    step_to(70);
    expect_at(70, 4'b0010, 4'b0010, "mode1_before_edit");
    in1 = 4'b1010;
    expect_at(71, 4'b0010, 4'b1010, "mode1_in1_edit");

    step_to(75);
    data = 2'd3;
    expect_at(82, 4'b1000, 4'b1000, "mode3_reached");

    step_to(84);
    expect_at(84, 4'b0001, 4'b0000, "async_rst_immediate");
    sys_rst_n = 1'b0;
    #1 probe = 1'b1;
    #1 probe = 1'b0;
    expect_at(85, 4'b0001, 4'b0000, "rst_held_mode3");

    step_to(86);
    sys_rst_n = 1'b1;
    expect_at(87, 4'b0001, 4'b0001, "rerelease_out_in0");
    expect_at(91, 4'b0001, 4'b0001, "refilter_not_yet");
    expect_at(92, 4'b1000, 4'b0001, "refilter_led");
    expect_at(93, 4'b1000, 4'b1000, "refilter_out");

    step_to(96);
    done = 1'b1;
  end

  // Monitor: pops every entry due at the current cycle on the falling edge or on an asynchronous probe.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge sys_clk or posedge probe);
      while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc < cyc_cnt) begin
          errors++;
          $display("FAIL %s: sampled at cyc %0d, required at cyc %0d", e.name, cyc_cnt, e.cyc);
        end else if (led !== e.led || out !== e.out) begin
          errors++;
          $display("FAIL %s @cyc %0d: led=%b out=%b, expected led=%b out=%b",
                   e.name, cyc_cnt, led, out, e.led, e.out);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by 100000 ns");
    $fatal(1, "timeout");
  end

endmodule
